// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID boundary into decode.
package fetch_stage_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    KILL  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus4;
    logic               valid;
  } if_id_t;

  // Sequential PC step; 32-bit modulo so 0xFFFF_FFFC rolls over to 0.
  function automatic logic [INSTR_W-1:0] pc_inc(input logic [INSTR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise the slot becomes a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   hold_i,
  input  logic   flush_i,
  input  if_id_t data_i,
  output if_id_t data_o
);

  if_id_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (flush_i || (!hold_i && !load_i)) begin
      // A bubble keeps the stale pc_plus4; decode ignores it when valid is low.
      slot_d.instr = NOP_INSTR;
      slot_d.valid = 1'b0;
    end else if (!hold_i) begin
      slot_d = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else begin
      slot_q <= slot_d;
    end
  end

  assign data_o = slot_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, req/ack memory port, skid buffer and IF/ID register.
// Optional FETCH_PERF_COUNTERS_EN adds fetch_count and stall_cycles outputs.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_addr,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_cycles
`endif
);

  localparam if_id_t SLOT_EMPTY = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] kill_addr_q, kill_addr_d;
  if_id_t             skid_q, skid_d;

  logic               ack_ok;
  logic [INSTR_W-1:0] pc_plus4;
  if_id_t             fetched;
  if_id_t             ld_data;
  logic               load;
  logic               flush;
  if_id_t             slot;

  assign imem_req  = !rst && (state_q != HOLD);
  // While killing, the memory still owes a response for the address it was given.
  assign imem_addr = (state_q == KILL) ? kill_addr_q : pc_q;
  assign ack_ok    = imem_req && imem_ack;
  assign pc_plus4  = pc_inc(pc_q);
  assign fetched   = '{instr: imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    skid_d      = skid_q;
    load        = 1'b0;
    flush       = 1'b0;
    ld_data     = fetched;
    if (branch_taken) begin
      pc_d   = branch_addr;
      flush  = 1'b1;
      skid_d = SLOT_EMPTY;
      case (state_q)
        FETCH: begin
          if (!ack_ok) begin
            state_d     = KILL;
            kill_addr_d = pc_q;
          end
        end
        KILL:    if (ack_ok) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (ack_ok) begin
            pc_d = pc_plus4;
            if (freeze) begin
              skid_d  = fetched;
              state_d = HOLD;
            end else begin
              load = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!freeze) begin
            ld_data = skid_q;
            load    = 1'b1;
            skid_d  = SLOT_EMPTY;
            state_d = FETCH;
          end
        end
        KILL:    if (ack_ok) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      skid_q      <= SLOT_EMPTY;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      skid_q      <= skid_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .hold_i  (freeze),
    .flush_i (flush),
    .data_i  (ld_data),
    .data_o  (slot)
  );

  assign pc_out      = slot.pc_plus4;
  assign instr_out   = slot.instr;
  assign instr_valid = slot.valid;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (load) fetch_count_q <= fetch_count_q + 32'd1;
      if (freeze || (state_q == KILL)) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural memory with programmable latency and an address scoreboard.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 0;
  bit          mem_en = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] sb_q[$];
  logic        fr_edge;

  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // Memory answers a few ns after each rising edge, once the request has waited mem_lat cycles.
  always @(posedge clk) begin
    #3;
    if (mem_en && imem_req && (wait_cnt >= mem_lat)) begin
      imem_ack   = 1'b1;
      imem_rdata = word_at(imem_addr);
      wait_cnt   = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hBAD0_BAD0;
      if (imem_req) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  // A new IF/ID slot appears on any edge without freeze that leaves instr_valid high.
  always @(posedge clk) begin
    fr_edge = freeze;
    #1;
    if (!rst && instr_valid && !fr_edge) begin
      chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        logic [31:0] a;
        a = sb_q.pop_front();
        chk("sb_instr", instr_out, word_at(a));
        chk("sb_pc_plus4", pc_out, a + 32'd4);
      end
    end
  end

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    mem_lat      = lat;
    mem_en       = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_valid", 32'(instr_valid), 32'd0);

    // Zero-wait streaming
    do_reset(0);
    for (int k = 0; k < 5; k++) sb_q.push_back(32'(4 * k));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s1_addr", imem_addr, 32'(4 * k));
      chk("s1_req", 32'(imem_req), 32'd1);
      if (k > 0) begin
        chk("s1_pc_out", pc_out, 32'(4 * k));
        chk("s1_valid", 32'(instr_valid), 32'd1);
      end
    end
    mem_en = 1'b0;
    @(negedge clk);
    chk("s1_last_pc", pc_out, 32'd20);
    @(negedge clk);
    chk("s1_bubble_valid", 32'(instr_valid), 32'd0);
    chk("s1_bubble_instr", instr_out, NOP);

    // Freeze for three cycles while the word at 8 is acknowledged
    do_reset(0);
    for (int k = 0; k < 5; k++) sb_q.push_back(32'(4 * k));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("s2_addr8", imem_addr, 32'h8);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s2_hold_req", 32'(imem_req), 32'd0);
      chk("s2_hold_pc", pc_out, 32'h8);
      chk("s2_hold_instr", instr_out, word_at(32'h4));
    end
    freeze = 1'b0;
    @(negedge clk);
    chk("s2_skid_pc", pc_out, 32'hC);
    chk("s2_skid_instr", instr_out, word_at(32'h8));
    chk("s2_resume_addr", imem_addr, 32'hC);
    chk("s2_resume_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    chk("s2_next_pc", pc_out, 32'h10);
    mem_en = 1'b0;
    @(negedge clk);
    chk("s2_last_pc", pc_out, 32'h14);

    // Redirect during a two-cycle memory wait: outstanding word must be dropped
    do_reset(0);
    sb_q.push_back(32'h100);
    @(negedge clk);
    chk("s3_addr0", imem_addr, 32'h0);
    branch_taken = 1'b1;
    branch_addr  = 32'h20;
    mem_lat      = 1;
    @(negedge clk);
    chk("s3_addr20", imem_addr, 32'h20);
    chk("s3_flush_valid", 32'(instr_valid), 32'd0);
    branch_addr = 32'h100;
    @(negedge clk);
    chk("s3_kill_addr", imem_addr, 32'h20);
    chk("s3_kill_req", 32'(imem_req), 32'd1);
    branch_taken = 1'b0;
    @(negedge clk);
    chk("s3_target_addr", imem_addr, 32'h100);
    chk("s3_drop_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("s3_wait_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("s3_tgt_pc", pc_out, 32'h104);
    chk("s3_tgt_valid", 32'(instr_valid), 32'd1);
    mem_en = 1'b0;

    // Branch with ack at 0x40, then PC wrap from 0xFFFF_FFFC
    do_reset(0);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h3C);
    sb_q.push_back(32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    chk("s4_addr4", imem_addr, 32'h4);
    branch_taken = 1'b1;
    branch_addr  = 32'h3C;
    @(negedge clk);
    chk("s4_addr3c", imem_addr, 32'h3C);
    branch_taken = 1'b0;
    @(negedge clk);
    chk("s4_addr40", imem_addr, 32'h40);
    chk("s4_pre_valid", 32'(instr_valid), 32'd1);
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("s4_flush_valid", 32'(instr_valid), 32'd0);
    chk("s4_flush_instr", instr_out, NOP);
    chk("s4_redirect_addr", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    mem_en       = 1'b0;
    @(negedge clk);
    chk("s5_wrap_pc", pc_out, 32'h0);
    chk("s5_wrap_valid", 32'(instr_valid), 32'd1);
    chk("s5_wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset while a request is waiting
    do_reset(0);
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    @(negedge clk);
    @(negedge clk);
    mem_lat = 3;
    @(negedge clk);
    chk("s6_wait_addr", imem_addr, 32'h8);
    chk("s6_wait_pc", pc_out, 32'h8);
    @(negedge clk);
    chk("s6_wait_addr2", imem_addr, 32'h8);
    rst = 1'b1;
    #1;
    chk("s6_rst_req", 32'(imem_req), 32'd0);
    chk("s6_rst_addr", imem_addr, 32'h0);
    chk("s6_rst_pc", pc_out, 32'h0);
    chk("s6_rst_instr", instr_out, NOP);
    @(negedge clk);
    chk("s6_rst_req_held", 32'(imem_req), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("s6_post_addr", imem_addr, 32'h0);
    chk("s6_post_req", 32'(imem_req), 32'd1);
    mem_en = 1'b0;
    @(negedge clk);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Contains the IF/ID pipeline register that feeds decode: instruction, PC+4, valid.
- Obeys freeze from the hazard unit and redirect/flush from decode's branch_taken/branch_addr.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven to decode when the slot is a bubble.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- freeze  input  1  decode stalled: IF/ID register must hold.
- branch_taken  input  1  redirect pulse from decode.
- branch_addr  input  32  redirect target, valid when branch_taken=1.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  32  request address; equals PC.
- imem_ack  input  1  memory response; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- pc_out  output  32  IF/ID: address of delivered instruction + 4.
- instr_out  output  32  IF/ID: instruction word.
- instr_valid  output  1  IF/ID: slot holds a real instruction.

Behaviour:
- Reset (async): PC=RESET_PC, state=FETCH, pc_out=0, instr_out=NOP_INSTR, instr_valid=0, skid buffer cleared.
- imem_req is combinational: 1 in FETCH and KILL, 0 in HOLD and while rst=1.
- imem_addr=PC; held stable while imem_req=1 and no ack. A transaction completes on a clock edge where imem_req=1 and imem_ack=1. Zero-wait memory (ack in the request cycle) sustains 1 instruction/cycle.
- FETCH, ack=1, freeze=0: IF/ID <= {rdata, PC+4, valid=1}; PC <= PC+4; stay FETCH.
- FETCH, ack=1, freeze=1: skid <= {rdata, PC+4}; PC <= PC+4; go HOLD. IF/ID unchanged.
- FETCH, ack=0: if freeze=0, IF/ID instr_valid <= 0 and instr_out <= NOP_INSTR (bubble); if freeze=1, IF/ID holds.
- HOLD, freeze=1: all state holds; no request.
- HOLD, freeze=0: IF/ID <= skid with valid=1; go FETCH. New request starts the following cycle.
- KILL (response outstanding for a discarded address): imem_addr keeps the old address until ack. On ack, discard data; PC already holds the target; go FETCH. IF/ID bubbles while in KILL unless freeze=1.
- branch_taken=1 (priority over freeze and ack):
  - PC <= branch_addr.
  - IF/ID instr_valid <= 0, instr_out <= NOP_INSTR.
  - Skid is discarded.
  - Next state: FETCH if state=HOLD, or if state=FETCH and ack=1 in that cycle; KILL if state=FETCH with ack=0; stays KILL if already in KILL.
- branch_taken in KILL with simultaneous ack: data dropped, PC <= branch_addr, go FETCH.
- PC arithmetic is 32-bit modulo: PC+4 from 32'hFFFF_FFFC wraps to 0 with no error.
- Reset asserted mid-transaction: the outstanding request is abandoned. The memory must tolerate the withdrawn request.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- When defined, adds two outputs:
  - fetch_count (32): increments on every instruction written into IF/ID with valid=1.
  - stall_cycles (32): increments every cycle freeze=1 or state=KILL.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared pipeline package:
  - fetch state enum {FETCH, KILL, HOLD}.
  - NOP_INSTR and RESET_PC defaults.
  - INSTR_W=32.
  - IF/ID payload struct {instr, pc_plus4, valid}, reused by the decode stage.
- Sub-module if_id_reg: the IF/ID register with load, hold (freeze) and flush inputs; async reset to bubble.
- FSM, PC and skid buffer stay in fetch_stage.

Test Plan:
- Zero-wait memory (ack tied 1), no freeze, RESET_PC=0 -> imem_addr 0,4,8,12 on consecutive cycles; pc_out 4,8,12 one cycle later with instr_valid=1.
- Freeze held 3 cycles while ack=1 at PC=8 -> state HOLD, imem_req=0, IF/ID unchanged; after freeze drops, instr_out=word@8, pc_out=12, then fetch resumes at 12.
- Memory with 2-cycle latency, branch_taken to 0x100 in the first request cycle at PC=0x20 -> imem_addr stays 0x20 until ack, data dropped, next request 0x100; no valid slot carries 0x20's word.
- branch_taken together with ack in FETCH at PC=0x40 -> IF/ID flushed (valid=0, instr_out=NOP_INSTR); next imem_addr=branch_addr.
- PC=32'hFFFF_FFFC, ack -> pc_out=0, next imem_addr=0.
- rst asserted mid-wait with ack low -> outputs immediately reset values; imem_req=0 while rst=1, then requests RESET_PC after release.
